// File: rtl/sha256_pkg.sv
// Shared widths and types for the SHA-256 config arbiter slice.
package sha256_pkg;

  localparam int SHA256_ID_W   = 6;
  localparam int SHA256_SIZE_W = 64;

  typedef logic [1:0] sha256_scheme_t;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

endpackage

// File: rtl/sha256_rr_arbiter.sv
// Combinational cyclic priority pick: first asserted request strictly after ptr_i,
// wrapping around so ptr_i itself has the lowest priority.
module sha256_rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               any_o
);

  logic [IDX_W-1:0] cand;

  // NUM_REQ is a power of two, so the index addition wraps for free.
  always_comb begin
    cand  = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = ptr_i + IDX_W'(k);
      if (!any_o && req_i[cand]) begin
        any_o = 1'b1;
        idx_o = cand;
      end
    end
    gnt_o = NUM_REQ'(any_o) << idx_o;
  end

endmodule

// File: rtl/sha256_cfg_arbiter.sv
// Round-robin arbiter sharing the synchroniser's cfg/ID input pair between requesters;
// the grant is held for a whole message and every beat is tagged with a message ID.
module sha256_cfg_arbiter
  import sha256_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int ID_W    = SHA256_ID_W,
  parameter  int SIZE_W  = SHA256_SIZE_W,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      sync_rst,
  input  logic                      en,
  input  logic [NUM_REQ*SIZE_W-1:0] req_size,
  input  logic [NUM_REQ*2-1:0]      req_scheme,
  input  logic [NUM_REQ-1:0]        req_last,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [SIZE_W-1:0]         cfg_out_size,
  output logic [1:0]                cfg_out_scheme,
  output logic                      cfg_out_last,
  output logic                      cfg_out_valid,
  input  logic                      cfg_out_ready,
  output logic [ID_W-1:0]           id_out,
  output logic                      id_out_last,
  output logic                      id_out_valid,
  input  logic                      id_out_ready,
  output logic [IDX_W-1:0]          grant_idx,
  output logic                      busy
);

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] grant_oh_q, grant_oh_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]  id_cnt_q, id_cnt_d;

  logic [SIZE_W-1:0] cfg_size_q, cfg_size_d;
  sha256_scheme_t    cfg_scheme_q, cfg_scheme_d;
  logic              cfg_last_q, cfg_last_d;
  logic              cfg_valid_q, cfg_valid_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic              id_last_q, id_last_d;
  logic              id_valid_q, id_valid_d;

  logic [NUM_REQ-1:0] pick_gnt;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
  logic               slot_free;
  logic               accept;
  logic [SIZE_W-1:0]  sel_size;
  sha256_scheme_t     sel_scheme;
  logic               sel_last;

  sha256_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .req_i (req_valid),
    .ptr_i (rr_ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  // A beat may only enter when both slots will be empty after this edge,
  // which keeps the cfg and ID streams paired beat for beat.
  assign slot_free  = (~cfg_valid_q | cfg_out_ready) & (~id_valid_q | id_out_ready);
  assign req_ready  = (state_q == LOCKED && en && slot_free) ? grant_oh_q : '0;
  assign accept     = |(req_ready & req_valid);
  assign sel_size   = req_size[int'(grant_q)*SIZE_W +: SIZE_W];
  assign sel_scheme = req_scheme[int'(grant_q)*2 +: 2];
  assign sel_last   = req_last[grant_q];

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    grant_oh_d = grant_oh_q;
    rr_ptr_d   = rr_ptr_q;
    id_cnt_d   = id_cnt_q;
    case (state_q)
      IDLE: begin
        if (en && pick_any) begin
          state_d    = LOCKED;
          grant_d    = pick_idx;
          grant_oh_d = pick_gnt;
          rr_ptr_d   = pick_idx;
        end
      end
      LOCKED: begin
        if (accept && sel_last) begin
          state_d  = IDLE;
          id_cnt_d = id_cnt_q + ID_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cfg_size_d   = cfg_size_q;
    cfg_scheme_d = cfg_scheme_q;
    cfg_last_d   = cfg_last_q;
    cfg_valid_d  = cfg_valid_q & ~cfg_out_ready;
    id_d         = id_q;
    id_last_d    = id_last_q;
    id_valid_d   = id_valid_q & ~id_out_ready;
    if (accept) begin
      cfg_size_d   = sel_size;
      cfg_scheme_d = sel_scheme;
      cfg_last_d   = sel_last;
      cfg_valid_d  = 1'b1;
      id_d         = id_cnt_q;
      id_last_d    = sel_last;
      id_valid_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      grant_oh_q   <= '0;
      rr_ptr_q     <= IDX_W'(NUM_REQ - 1);
      id_cnt_q     <= '0;
      cfg_size_q   <= '0;
      cfg_scheme_q <= '0;
      cfg_last_q   <= 1'b0;
      cfg_valid_q  <= 1'b0;
      id_q         <= '0;
      id_last_q    <= 1'b0;
      id_valid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      grant_oh_q   <= grant_oh_d;
      rr_ptr_q     <= rr_ptr_d;
      id_cnt_q     <= id_cnt_d;
      cfg_size_q   <= cfg_size_d;
      cfg_scheme_q <= cfg_scheme_d;
      cfg_last_q   <= cfg_last_d;
      cfg_valid_q  <= cfg_valid_d;
      id_q         <= id_d;
      id_last_q    <= id_last_d;
      id_valid_q   <= id_valid_d;
    end
  end

  assign cfg_out_size   = cfg_size_q;
  assign cfg_out_scheme = cfg_scheme_q;
  assign cfg_out_last   = cfg_last_q;
  assign cfg_out_valid  = cfg_valid_q;
  assign id_out         = id_q;
  assign id_out_last    = id_last_q;
  assign id_out_valid   = id_valid_q;
  assign grant_idx      = grant_q;
  assign busy           = (state_q == LOCKED);

endmodule

// File: tb/tb_sha256_cfg_arbiter.sv
// Bench for sha256_cfg_arbiter: directed sequences, a per-cycle vector table and
// randomized traffic, all compared against a queue-based transaction model.
module tb_sha256_cfg_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 6;
  localparam int SIZE_W  = 64;

  logic                      clk = 1'b0;
  logic                      sync_rst;
  logic                      en;
  logic [NUM_REQ*SIZE_W-1:0] req_size;
  logic [NUM_REQ*2-1:0]      req_scheme;
  logic [NUM_REQ-1:0]        req_last;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [SIZE_W-1:0]         cfg_out_size;
  logic [1:0]                cfg_out_scheme;
  logic                      cfg_out_last;
  logic                      cfg_out_valid;
  logic                      cfg_out_ready;
  logic [ID_W-1:0]           id_out;
  logic                      id_out_last;
  logic                      id_out_valid;
  logic                      id_out_ready;
  logic [1:0]                grant_idx;
  logic                      busy;

  always #5 clk = ~clk;

  sha256_cfg_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .SIZE_W(SIZE_W)) dut (
    .clk(clk), .sync_rst(sync_rst), .en(en),
    .req_size(req_size), .req_scheme(req_scheme), .req_last(req_last),
    .req_valid(req_valid), .req_ready(req_ready),
    .cfg_out_size(cfg_out_size), .cfg_out_scheme(cfg_out_scheme),
    .cfg_out_last(cfg_out_last), .cfg_out_valid(cfg_out_valid), .cfg_out_ready(cfg_out_ready),
    .id_out(id_out), .id_out_last(id_out_last), .id_out_valid(id_out_valid),
    .id_out_ready(id_out_ready), .grant_idx(grant_idx), .busy(busy)
  );

  typedef struct {
    logic [SIZE_W-1:0] size;
    logic [1:0]        scheme;
    logic              last;
    logic [ID_W-1:0]   id;
  } beat_t;

  typedef struct {
    logic [3:0]        reqValid;
    logic [3:0]        reqLast;
    logic              cfgRdy;
    logic              idRdy;
    logic [3:0]        expReady;
    logic              expValid;
    logic [SIZE_W-1:0] expSize;
    logic [ID_W-1:0]   expId;
    logic [1:0]        expGrant;
    logic              expBusy;
  } vec_t;

  int nCompared   = 0;
  int nMismatched = 0;

  // Requester behaviour: remaining beats of the current message per requester.
  int                remBeats[NUM_REQ];
  bit                validOn[NUM_REQ];
  bit                autoRefill[NUM_REQ];
  logic [SIZE_W-1:0] curSize[NUM_REQ];
  logic [1:0]        curScheme[NUM_REQ];
  bit                randomData;

  // Transaction model: owner/pointer/ID plus one queue per output stream.
  bit    mKnown = 1'b0;
  bit    mLocked;
  int    mOwner, mPtr, mIdCnt, mGrant;
  beat_t mCfgQ[$];
  beat_t mIdQ[$];

  logic [SIZE_W-1:0] obsSize[$];
  logic [ID_W-1:0]   obsId[$];

  vec_t vecs[11];

  task automatic cmp(input string name, input logic [SIZE_W-1:0] act, input logic [SIZE_W-1:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [SIZE_W-1:0] randSize();
    logic [SIZE_W-1:0] s;
    s = {$urandom(), $urandom()};
    if ($urandom_range(0, 7) == 0) s = '0;
    return s;
  endfunction

  function automatic logic [NUM_REQ-1:0] modelReqReady();
    logic [NUM_REQ-1:0] r;
    bit slotFree;
    r = '0;
    slotFree = (mCfgQ.size() == 0 || cfg_out_ready) && (mIdQ.size() == 0 || id_out_ready);
    if (mLocked && en && slotFree) r[mOwner] = 1'b1;
    return r;
  endfunction

  task automatic startMsg(input int i, input int beats, input logic [SIZE_W-1:0] size, input logic [1:0] scheme);
    remBeats[i]  = beats;
    curSize[i]   = size;
    curScheme[i] = scheme;
    validOn[i]   = 1'b1;
  endtask

  task automatic applyStimulus();
    for (int i = 0; i < NUM_REQ; i++) begin
      req_valid[i]                  = (remBeats[i] > 0) && validOn[i];
      req_last[i]                   = (remBeats[i] == 1);
      req_size[i*SIZE_W +: SIZE_W]  = curSize[i];
      req_scheme[i*2 +: 2]          = curScheme[i];
    end
  endtask

  task automatic checkOutput();
    if (cfg_out_valid && cfg_out_ready) obsSize.push_back(cfg_out_size);
    if (id_out_valid && id_out_ready) obsId.push_back(id_out);
    if (!mKnown) return;
    cmp("req_ready", 64'(req_ready), 64'(modelReqReady()));
    cmp("cfg_valid", 64'(cfg_out_valid), 64'(mCfgQ.size() != 0));
    if (mCfgQ.size() != 0) begin
      cmp("cfg_size", cfg_out_size, mCfgQ[0].size);
      cmp("cfg_scheme", 64'(cfg_out_scheme), 64'(mCfgQ[0].scheme));
      cmp("cfg_last", 64'(cfg_out_last), 64'(mCfgQ[0].last));
    end
    cmp("id_valid", 64'(id_out_valid), 64'(mIdQ.size() != 0));
    if (mIdQ.size() != 0) begin
      cmp("id_out", 64'(id_out), 64'(mIdQ[0].id));
      cmp("id_last", 64'(id_out_last), 64'(mIdQ[0].last));
    end
    cmp("grant_idx", 64'(grant_idx), 64'(mGrant));
    cmp("busy", 64'(busy), 64'(mLocked));
  endtask

  task automatic modelUpdate(output int hsIdx);
    logic [NUM_REQ-1:0] rr;
    bit    wasLocked;
    bit    found;
    int    c;
    beat_t b;
    hsIdx = -1;
    if (sync_rst) begin
      mKnown  = 1'b1;
      mLocked = 1'b0;
      mOwner  = 0;
      mPtr    = NUM_REQ - 1;
      mIdCnt  = 0;
      mGrant  = 0;
      mCfgQ.delete();
      mIdQ.delete();
      return;
    end
    if (!mKnown) return;
    rr        = modelReqReady();
    wasLocked = mLocked;
    if (mCfgQ.size() != 0 && cfg_out_ready) void'(mCfgQ.pop_front());
    if (mIdQ.size() != 0 && id_out_ready) void'(mIdQ.pop_front());
    if (rr[mOwner] && req_valid[mOwner]) begin
      hsIdx    = mOwner;
      b.size   = req_size[mOwner*SIZE_W +: SIZE_W];
      b.scheme = req_scheme[mOwner*2 +: 2];
      b.last   = req_last[mOwner];
      b.id     = ID_W'(mIdCnt);
      mCfgQ.push_back(b);
      mIdQ.push_back(b);
      if (b.last) begin
        mLocked = 1'b0;
        mIdCnt  = (mIdCnt + 1) % (1 << ID_W);
      end
    end
    if (!wasLocked && en) begin
      found = 1'b0;
      for (int k = 1; k <= NUM_REQ; k++) begin
        c = (mPtr + k) % NUM_REQ;
        if (!found && req_valid[c]) begin
          found   = 1'b1;
          mOwner  = c;
          mPtr    = c;
          mGrant  = c;
          mLocked = 1'b1;
        end
      end
    end
  endtask

  task automatic requesterUpdate(input int hsIdx);
    if (sync_rst) begin
      for (int i = 0; i < NUM_REQ; i++) remBeats[i] = 0;
    end else if (hsIdx >= 0) begin
      remBeats[hsIdx]--;
      if (remBeats[hsIdx] == 0 && autoRefill[hsIdx]) remBeats[hsIdx] = 1;
      if (randomData) begin
        curSize[hsIdx]   = randSize();
        curScheme[hsIdx] = 2'($urandom_range(0, 3));
      end
    end
  endtask

  task automatic driveAndSample();
    applyStimulus();
    @(negedge clk);
    checkOutput();
  endtask

  task automatic advance();
    int hs;
    @(posedge clk);
    modelUpdate(hs);
    requesterUpdate(hs);
    #1;
  endtask

  task automatic tick();
    driveAndSample();
    advance();
  endtask

  task automatic checkAllZero(input string tag);
    cmp({tag, "_req_ready"}, 64'(req_ready), 64'd0);
    cmp({tag, "_cfg_valid"}, 64'(cfg_out_valid), 64'd0);
    cmp({tag, "_cfg_size"}, cfg_out_size, 64'd0);
    cmp({tag, "_cfg_scheme"}, 64'(cfg_out_scheme), 64'd0);
    cmp({tag, "_cfg_last"}, 64'(cfg_out_last), 64'd0);
    cmp({tag, "_id_valid"}, 64'(id_out_valid), 64'd0);
    cmp({tag, "_id_out"}, 64'(id_out), 64'd0);
    cmp({tag, "_id_last"}, 64'(id_out_last), 64'd0);
    cmp({tag, "_grant"}, 64'(grant_idx), 64'd0);
    cmp({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  task automatic resetDut();
    for (int i = 0; i < NUM_REQ; i++) begin
      remBeats[i]   = 0;
      validOn[i]    = 1'b1;
      autoRefill[i] = 1'b0;
      curSize[i]    = '0;
      curScheme[i]  = '0;
    end
    randomData    = 1'b0;
    en            = 1'b1;
    cfg_out_ready = 1'b1;
    id_out_ready  = 1'b1;
    sync_rst      = 1'b1;
    tick();
    tick();
    sync_rst = 1'b0;
    obsSize.delete();
    obsId.delete();
    checkAllZero("reset");
  endtask

  initial begin
    int viol;
    bit req1LastSeen;

    // Single beat straight after reset.
    resetDut();
    startMsg(0, 1, 64'd512, 2'd1);
    tick();
    tick();
    cmp("t1_cfg_valid", 64'(cfg_out_valid), 64'd1);
    cmp("t1_cfg_size", cfg_out_size, 64'd512);
    cmp("t1_cfg_scheme", 64'(cfg_out_scheme), 64'd1);
    cmp("t1_cfg_last", 64'(cfg_out_last), 64'd1);
    cmp("t1_id_valid", 64'(id_out_valid), 64'd1);
    cmp("t1_id_out", 64'(id_out), 64'd0);
    cmp("t1_id_last", 64'(id_out_last), 64'd1);

    // All four requesters valid with single-beat messages: grants rotate 0,1,2,3,0.
    vecs[0]  = '{4'hF, 4'hF, 1'b1, 1'b1, 4'b0000, 1'b0, 64'd0,   6'd0, 2'd0, 1'b0};
    vecs[1]  = '{4'hF, 4'hF, 1'b1, 1'b1, 4'b0001, 1'b0, 64'd0,   6'd0, 2'd0, 1'b1};
    vecs[2]  = '{4'hF, 4'hF, 1'b1, 1'b1, 4'b0000, 1'b1, 64'd100, 6'd0, 2'd0, 1'b0};
    vecs[3]  = '{4'hF, 4'hF, 1'b1, 1'b1, 4'b0010, 1'b0, 64'd0,   6'd0, 2'd1, 1'b1};
    vecs[4]  = '{4'hF, 4'hF, 1'b1, 1'b1, 4'b0000, 1'b1, 64'd101, 6'd1, 2'd1, 1'b0};
    vecs[5]  = '{4'hF, 4'hF, 1'b1, 1'b1, 4'b0100, 1'b0, 64'd0,   6'd0, 2'd2, 1'b1};
    vecs[6]  = '{4'hF, 4'hF, 1'b1, 1'b1, 4'b0000, 1'b1, 64'd102, 6'd2, 2'd2, 1'b0};
    vecs[7]  = '{4'hF, 4'hF, 1'b1, 1'b1, 4'b1000, 1'b0, 64'd0,   6'd0, 2'd3, 1'b1};
    vecs[8]  = '{4'hF, 4'hF, 1'b1, 1'b1, 4'b0000, 1'b1, 64'd103, 6'd3, 2'd3, 1'b0};
    vecs[9]  = '{4'hF, 4'hF, 1'b1, 1'b1, 4'b0001, 1'b0, 64'd0,   6'd0, 2'd0, 1'b1};
    vecs[10] = '{4'hF, 4'hF, 1'b1, 1'b1, 4'b0000, 1'b1, 64'd100, 6'd4, 2'd0, 1'b0};
    resetDut();
    for (int i = 0; i < NUM_REQ; i++) req_size[i*SIZE_W +: SIZE_W] = 64'(100 + i);
    req_scheme = '0;
    for (int r = 0; r < 11; r++) begin
      req_valid     = vecs[r].reqValid;
      req_last      = vecs[r].reqLast;
      cfg_out_ready = vecs[r].cfgRdy;
      id_out_ready  = vecs[r].idRdy;
      @(negedge clk);
      checkOutput();
      cmp($sformatf("tbl%0d_ready", r), 64'(req_ready), 64'(vecs[r].expReady));
      cmp($sformatf("tbl%0d_cfg_valid", r), 64'(cfg_out_valid), 64'(vecs[r].expValid));
      cmp($sformatf("tbl%0d_id_valid", r), 64'(id_out_valid), 64'(vecs[r].expValid));
      cmp($sformatf("tbl%0d_grant", r), 64'(grant_idx), 64'(vecs[r].expGrant));
      cmp($sformatf("tbl%0d_busy", r), 64'(busy), 64'(vecs[r].expBusy));
      if (vecs[r].expValid) begin
        cmp($sformatf("tbl%0d_size", r), cfg_out_size, vecs[r].expSize);
        cmp($sformatf("tbl%0d_id", r), 64'(id_out), 64'(vecs[r].expId));
      end
      advance();
    end

    // Three-beat message from req1 holds off req2 until its last beat.
    resetDut();
    startMsg(1, 3, 64'h111, 2'd2);
    startMsg(2, 1, 64'h222, 2'd3);
    viol = 0;
    req1LastSeen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      driveAndSample();
      if (req_ready[2] && !req1LastSeen) viol++;
      if (req_ready[1] && req_valid[1] && req_last[1]) req1LastSeen = 1'b1;
      advance();
    end
    cmp("t3_req2_blocked", 64'(viol), 64'd0);
    cmp("t3_id_count", 64'(obsId.size()), 64'd4);
    if (obsId.size() >= 4) begin
      for (int k = 0; k < 3; k++) cmp($sformatf("t3_id%0d", k), 64'(obsId[k]), 64'd0);
      cmp("t3_id_req2", 64'(obsId[3]), 64'd1);
    end
    if (obsSize.size() >= 4) cmp("t3_size_req2", obsSize[3], 64'h222);

    // cfg backpressure for 5 cycles while the ID stream keeps draining.
    resetDut();
    startMsg(0, 2, 64'hAAA, 2'd1);
    tick();
    tick();
    curSize[0]    = 64'hBBB;
    cfg_out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      driveAndSample();
      cmp($sformatf("t4_ready_c%0d", k), 64'(req_ready), 64'd0);
      cmp($sformatf("t4_cfg_valid_c%0d", k), 64'(cfg_out_valid), 64'd1);
      cmp($sformatf("t4_cfg_size_c%0d", k), cfg_out_size, 64'hAAA);
      cmp($sformatf("t4_id_valid_c%0d", k), 64'(id_out_valid), 64'(k == 0));
      advance();
    end
    cfg_out_ready = 1'b1;
    for (int k = 0; k < 6; k++) tick();
    cmp("t4_cfg_beats", 64'(obsSize.size()), 64'd2);
    if (obsSize.size() >= 2) begin
      cmp("t4_beat0", obsSize[0], 64'hAAA);
      cmp("t4_beat1", obsSize[1], 64'hBBB);
    end
    cmp("t4_id_beats", 64'(obsId.size()), 64'd2);

    // 65 single-beat messages from one requester: ID wraps 63 -> 0.
    resetDut();
    startMsg(0, 1, 64'h5, 2'd0);
    autoRefill[0] = 1'b1;
    for (int k = 0; k < 134; k++) tick();
    cmp("t5_id_count", 64'(obsId.size() >= 65), 64'd1);
    if (obsId.size() >= 65) begin
      for (int k = 0; k < 65; k++) cmp($sformatf("t5_id%0d", k), 64'(obsId[k]), 64'(k % 64));
    end

    // Reset in the middle of a 3-beat message, then a fresh arbitration.
    resetDut();
    startMsg(0, 3, 64'h301, 2'd1);
    tick();
    tick();
    sync_rst = 1'b1;
    tick();
    sync_rst = 1'b0;
    checkAllZero("t6_midrst");
    obsSize.delete();
    obsId.delete();
    startMsg(0, 1, 64'h7, 2'd2);
    startMsg(3, 1, 64'h9, 2'd3);
    tick();
    cmp("t6_grant", 64'(grant_idx), 64'd0);
    cmp("t6_busy", 64'(busy), 64'd1);
    for (int k = 0; k < 6; k++) tick();
    cmp("t6_beats", 64'(obsId.size()), 64'd2);
    if (obsId.size() >= 2 && obsSize.size() >= 2) begin
      cmp("t6_id0", 64'(obsId[0]), 64'd0);
      cmp("t6_size0", obsSize[0], 64'h7);
      cmp("t6_id1", 64'(obsId[1]), 64'd1);
      cmp("t6_size1", obsSize[1], 64'h9);
    end

    // Randomized traffic: enable gaps, backpressure, valid drops, size 0.
    resetDut();
    randomData = 1'b1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      en            = ($urandom_range(0, 9) != 0);
      cfg_out_ready = ($urandom_range(0, 9) < 7);
      id_out_ready  = ($urandom_range(0, 9) < 7);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (remBeats[i] == 0 && $urandom_range(0, 4) == 0)
          startMsg(i, int'($urandom_range(1, 4)), randSize(), 2'($urandom_range(0, 3)));
        validOn[i] = ($urandom_range(0, 6) != 0);
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, compared=%0d mismatched=%0d", nCompared, nMismatched);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
